// File: rtl/cache_mem_arbiter_if.sv
// Signal bundle between the two cache masters (I-cache = m0, D-cache = m1),
// the memory arbiter and the shared line-wide main-memory port.
interface cache_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
);
  logic                  m0_r;
  logic                  m0_w;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [LINE_WIDTH-1:0] m0_w_data;
  logic [LINE_WIDTH-1:0] m0_r_data;
  logic                  m0_ready;

  logic                  m1_r;
  logic                  m1_w;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [LINE_WIDTH-1:0] m1_w_data;
  logic [LINE_WIDTH-1:0] m1_r_data;
  logic                  m1_ready;

  logic                  mem_r;
  logic                  mem_w;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_w_data;
  logic [LINE_WIDTH-1:0] mem_r_data;
  logic                  mem_ready;

  logic [CNT_WIDTH-1:0]  m0_grants;
  logic [CNT_WIDTH-1:0]  m1_grants;

  // The arbiter: consumes cache requests and memory responses
  modport master (
    input  m0_r, m0_w, m0_addr, m0_w_data,
    input  m1_r, m1_w, m1_addr, m1_w_data,
    input  mem_r_data, mem_ready,
    output m0_r_data, m0_ready, m1_r_data, m1_ready,
    output mem_r, mem_w, mem_addr, mem_w_data,
    output m0_grants, m1_grants
  );

  modport slave (
    output m0_r, m0_w, m0_addr, m0_w_data,
    output m1_r, m1_w, m1_addr, m1_w_data,
    output mem_r_data, mem_ready,
    input  m0_r_data, m0_ready, m1_r_data, m1_ready,
    input  mem_r, mem_w, mem_addr, mem_w_data,
    input  m0_grants, m1_grants
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache
// (m0) and the D-cache (m1), one transaction in flight, with grant counters.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int CNT_WIDTH  = 16
) (
  input logic                 clk,
  input logic                 rst,
  cache_mem_arbiter_if.master bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1'b1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [LINE_WIDTH-1:0] LINE_ZERO = {LINE_WIDTH{1'b0}};

  state_t                state_r;
  state_t                state_s;
  logic                  last_grant_r;
  logic                  id_r;
  logic                  op_r;
  logic                  abandoned_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [LINE_WIDTH-1:0] data_r;
  logic [CNT_WIDTH-1:0]  cnt0_r;
  logic [CNT_WIDTH-1:0]  cnt1_r;

  logic                  req0_s;
  logic                  req1_s;
  logic                  cur_req_s;
  logic                  grant_s;
  logic                  winner_s;
  logic                  win_w_s;
  logic [ADDR_WIDTH-1:0] win_addr_s;
  logic [LINE_WIDTH-1:0] win_data_s;
  logic                  deliver_s;
  logic                  mem_r_s;
  logic                  mem_w_s;
  logic [ADDR_WIDTH-1:0] mem_addr_s;
  logic [LINE_WIDTH-1:0] mem_w_data_s;

  assign req0_s     = bus.m0_r | bus.m0_w;
  assign req1_s     = bus.m1_r | bus.m1_w;
  assign cur_req_s  = id_r ? req1_s : req0_s;
  assign win_w_s    = winner_s ? bus.m1_w : bus.m0_w;
  assign win_addr_s = winner_s ? bus.m1_addr : bus.m0_addr;
  assign win_data_s = winner_s ? bus.m1_w_data : bus.m0_w_data;

  // Next-state, winner selection and combinational memory/completion outputs
  always_comb begin
    state_s      = state_r;
    grant_s      = 1'b0;
    winner_s     = 1'b0;
    deliver_s    = 1'b0;
    mem_r_s      = 1'b0;
    mem_w_s      = 1'b0;
    mem_addr_s   = ADDR_ZERO;
    mem_w_data_s = LINE_ZERO;
    case (state_r)
      IDLE: begin
        // On a tie the master that was not served last wins
        if (req0_s && req1_s) begin
          grant_s  = 1'b1;
          winner_s = ~last_grant_r;
        end else if (req0_s) begin
          grant_s  = 1'b1;
          winner_s = 1'b0;
        end else if (req1_s) begin
          grant_s  = 1'b1;
          winner_s = 1'b1;
        end else begin
          grant_s  = 1'b0;
          winner_s = 1'b0;
        end
        if (grant_s) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        mem_r_s      = ~op_r & ~bus.mem_ready;
        mem_w_s      = op_r & ~bus.mem_ready;
        mem_addr_s   = addr_r;
        mem_w_data_s = data_r;
        // Memory always completes; the pulse is only forwarded if still wanted
        if (bus.mem_ready) begin
          deliver_s = ~abandoned_r & cur_req_s;
          state_s   = IDLE;
        end else begin
          deliver_s = 1'b0;
          state_s   = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign bus.mem_r      = mem_r_s;
  assign bus.mem_w      = mem_w_s;
  assign bus.mem_addr   = mem_addr_s;
  assign bus.mem_w_data = mem_w_data_s;
  assign bus.m0_ready   = deliver_s & ~id_r;
  assign bus.m1_ready   = deliver_s & id_r;
  assign bus.m0_r_data  = (deliver_s & ~id_r) ? bus.mem_r_data : LINE_ZERO;
  assign bus.m1_r_data  = (deliver_s & id_r) ? bus.mem_r_data : LINE_ZERO;
  assign bus.m0_grants  = cnt0_r;
  assign bus.m1_grants  = cnt1_r;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request fields latched at grant, round-robin pointer, abandon flag, counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= 1'b1;
      id_r         <= 1'b0;
      op_r         <= 1'b0;
      abandoned_r  <= 1'b0;
      addr_r       <= ADDR_ZERO;
      data_r       <= LINE_ZERO;
      cnt0_r       <= CNT_ZERO;
      cnt1_r       <= CNT_ZERO;
    end else begin
      if (grant_s) begin
        id_r         <= winner_s;
        op_r         <= win_w_s;
        addr_r       <= win_addr_s;
        data_r       <= win_w_s ? win_data_s : LINE_ZERO;
        last_grant_r <= winner_s;
        abandoned_r  <= 1'b0;
        if (!winner_s) begin
          if (cnt0_r != CNT_MAX) begin
            cnt0_r <= cnt0_r + CNT_ONE;
          end
        end else begin
          if (cnt1_r != CNT_MAX) begin
            cnt1_r <= cnt1_r + CNT_ONE;
          end
        end
      end else if ((state_r == BUSY) && !cur_req_s) begin
        abandoned_r <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one 128-bit line-wide main-memory port between two cache masters: port 0 is the I-cache and port 1 is the D-cache.
- Both masters use the same interface as the cache-to-memory side:
  - level-held mem_r or mem_w request plus address and write line;
  - a single-cycle ready pulse completes the transaction.
- Round-robin arbitration, one outstanding transaction, request fields registered at grant.
- Saturating per-master grant counters for performance evaluation.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 128, line data width (4 words).
- CNT_WIDTH, 16, grant counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_r  in  1  master 0 line read request
- m0_w  in  1  master 0 line write request
- m0_addr  in  ADDR_WIDTH  master 0 line address
- m0_w_data  in  LINE_WIDTH  master 0 write line
- m0_r_data  out  LINE_WIDTH  master 0 read line
- m0_ready  out  1  master 0 completion pulse
- m1_r, m1_w, m1_addr, m1_w_data, m1_r_data, m1_ready  same as m0_*, for master 1
- mem_r  out  1  memory read request
- mem_w  out  1  memory write request
- mem_addr  out  ADDR_WIDTH  memory address
- mem_w_data  out  LINE_WIDTH  memory write line
- mem_r_data  in  LINE_WIDTH  memory read line
- mem_ready  in  1  memory completion pulse
- m0_grants  out  CNT_WIDTH  transactions granted to master 0
- m1_grants  out  CNT_WIDTH  transactions granted to master 1

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE, last_grant=1, so master 0 wins the first tie;
  - op/address/data registers, mem_r, mem_w, mem_addr, mem_w_data, both m*_ready, both m*_r_data and both counters = 0.
- Reset mid-transaction abandons the transaction: no ready pulse is issued and outputs drop immediately.
- Master k requests when mk_r|mk_w is high.
- If a master asserts both, it is a write; the read is seen after the write completes, as a new request.
- State IDLE:
  - mem_r=mem_w=0.
  - If any master requests, the winner is:
    - the sole requester; or
    - on a tie, the master that is not last_grant.
  - On the grant edge:
    - latch winner id, op (write if mk_w), mk_addr and mk_w_data;
    - last_grant <= winner;
    - winner's grant counter +1, saturating at all-ones;
    - go to BUSY.
  - mem_ready seen in IDLE is ignored.
- State BUSY:
  - mem_r = ~op_reg, mem_w = op_reg; mem_addr and mem_w_data driven from registers, constant for the whole transaction.
  - mem_w_data = 0 for reads.
  - When mem_ready=1, in the same cycle (combinational):
    - m<id>_ready = 1;
    - m<id>_r_data = mem_r_data;
    - mem_r and mem_w drop to 0;
    - next state = IDLE.
  - The non-granted master sees ready=0 and r_data=0 throughout.
- Latency:
  - request sampled at edge t;
  - memory request visible from cycle t+1;
  - mem_ready in cycle u gives master ready in cycle u;
  - next grant at edge u+1, next memory request in cycle u+2.
  - Best case is therefore one idle memory cycle between transactions.
- The granted master drops its request while BUSY and before mem_ready:
  - the memory transaction still runs to completion, since it cannot be aborted;
  - the ready pulse to the master is suppressed;
  - return to IDLE.
- A one-cycle request pulse in IDLE (the cache miss-cycle mem_w glitch) is therefore granted, but its completion is discarded once the master has dropped the request. The master must re-request for real work.
- The loser's request is held off with no ready pulse until the loser is granted.
- Fairness: with both masters continuously requesting, grants strictly alternate.
- mk_r_data and mk_ready are 0 whenever not completing that master's transaction.
- Counters hold at 2^CNT_WIDTH-1, with no wrap-around.

Test Plan:
- Single read: reset, m0_r=1, m0_addr=0x0000_0040, memory returns 0x…DDDD_CCCC_BBBB_AAAA after 3 cycles -> mem_r=1 and mem_addr=0x40 from the cycle after the request; m0_ready pulses exactly 1 cycle with that line; m1_ready stays 0; m0_grants=1.
- Write priority: m1_w=1 and m1_r=1, m1_addr=0x100, m1_w_data=0x1234… -> mem_w=1, mem_r=0, mem_w_data=0x1234… held constant until mem_ready; m1_ready pulses once.
- Tie after reset: m0_r and m1_r asserted together, both held -> grant order 0,1,0,1 over 4 transactions; m0_grants=m1_grants=2; no transaction starts before the previous one's mem_ready.
- Abandoned request: m1_w pulses high for 1 cycle in IDLE -> memory write to m1_addr completes; m1_ready stays 0; arbiter back in IDLE the cycle after mem_ready.
- Reset mid-BUSY: rst asserted 2 cycles into a read -> mem_r, mem_w and both readies go to 0 immediately; counters go to 0; after release, pending m0_r is granted first.
- Saturation: CNT_WIDTH=2, six m0 transactions -> m0_grants reads 1,2,3,3,3,3.
